// File: rtl/pc_fetch_ctrl.sv
// Program-counter register and fetch sequencer for the single-cycle RV32 core.
// Selects the next PC from the adder sums, traps misaligned targets and counts accepted fetches.
module pc_fetch_ctrl #(
  parameter int unsigned       WIDTH        = 32,
  parameter logic [WIDTH-1:0]  RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0]  TRAP_VECTOR  = WIDTH'(32'h0000_0100)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic [WIDTH-1:0] pc_plus4,
  input  logic [WIDTH-1:0] pc_target,
  input  logic             pc_src,
  input  logic             imem_ready,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  output logic [WIDTH-1:0] pc,
  output logic             instr_valid,
  output logic             misalign,
  output logic [WIDTH-1:0] fetch_count
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_TRAP  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             mis_q, mis_d;
  logic             req_q, req_d;
  logic             accept_s;
  logic [WIDTH-1:0] next_pc_s;

  function automatic logic is_misaligned(input logic [WIDTH-1:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

  assign next_pc_s = pc_src ? pc_target : pc_plus4;

  // Next-state, next-PC, sticky flag and counter decode
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    cnt_d    = cnt_q;
    mis_d    = mis_q;
    accept_s = 1'b0;
    case (state_q)
      ST_BOOT: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (imem_ready && !stall) begin
          accept_s = 1'b1;
          cnt_d    = cnt_q + WIDTH'(1);
          if (is_misaligned(next_pc_s)) begin
            pc_d    = TRAP_VECTOR;
            mis_d   = 1'b1;
            state_d = ST_TRAP;
          end else begin
            pc_d    = next_pc_s;
            state_d = ST_FETCH;
          end
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_TRAP: begin
        state_d = ST_FETCH;
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
    // Request is a registered decode of the state we are about to enter
    req_d = (state_d == ST_FETCH);
  end

  // State and datapath registers with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_VECTOR;
      cnt_q   <= '0;
      mis_q   <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      mis_q   <= mis_d;
      req_q   <= req_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr_valid = accept_s;
  assign misalign    = mis_q;
  assign fetch_count = cnt_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed self-checking bench for pc_fetch_ctrl; a second 8-bit instance covers counter wrap.
module tb_pc_fetch_ctrl;

  logic        clk;
  logic        reset;
  logic        stall;
  logic [31:0] pc_plus4;
  logic [31:0] pc_target;
  logic        pc_src;
  logic        imem_ready;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] pc;
  logic        instr_valid;
  logic        misalign;
  logic [31:0] fetch_count;

  logic        reset8;
  logic [7:0]  plus4_8;
  logic        req8;
  logic [7:0]  addr8;
  logic [7:0]  pc8;
  logic        valid8;
  logic        mis8;
  logic [7:0]  cnt8;

  int total = 0;
  int bad   = 0;

  pc_fetch_ctrl dut (
    .clk(clk), .reset(reset), .stall(stall), .pc_plus4(pc_plus4),
    .pc_target(pc_target), .pc_src(pc_src), .imem_ready(imem_ready),
    .imem_req(imem_req), .imem_addr(imem_addr), .pc(pc),
    .instr_valid(instr_valid), .misalign(misalign), .fetch_count(fetch_count)
  );

  pc_fetch_ctrl #(.WIDTH(8), .RESET_VECTOR(8'h00), .TRAP_VECTOR(8'h10)) dut8 (
    .clk(clk), .reset(reset8), .stall(1'b0), .pc_plus4(plus4_8),
    .pc_target(8'h00), .pc_src(1'b0), .imem_ready(1'b1),
    .imem_req(req8), .imem_addr(addr8), .pc(pc8),
    .instr_valid(valid8), .misalign(mis8), .fetch_count(cnt8)
  );

  // Environment stand-in for the PC+4 adder of the narrow instance
  assign plus4_8 = pc8 + 8'd4;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; reset8 = 1'b1; stall = 1'b0; pc_plus4 = 32'h0;
    pc_target = 32'h0; pc_src = 1'b0; imem_ready = 1'b0;
    cyc(); cyc();
    chk("rst_pc", pc, 32'h0);
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    chk("rst_valid", {31'b0, instr_valid}, 32'h0);
    chk("rst_mis", {31'b0, misalign}, 32'h0);
    chk("rst_cnt", fetch_count, 32'h0);

    // Test 1: boot then sequential fetch
    reset = 1'b0;
    #1 chk("boot_req", {31'b0, imem_req}, 32'h0);
    cyc();
    imem_ready = 1'b1; pc_plus4 = 32'h4;
    #1 chk("first_req", {31'b0, imem_req}, 32'h1);
    chk("first_addr", imem_addr, 32'h0);
    chk("first_valid", {31'b0, instr_valid}, 32'h1);
    cyc();
    pc_plus4 = 32'h8;
    #1 chk("seq_pc4", pc, 32'h4);
    cyc();
    pc_plus4 = 32'hC;
    #1 chk("seq_pc8", pc, 32'h8);
    cyc();
    #1 chk("seq_pc12", pc, 32'hC);
    chk("cnt3", fetch_count, 32'h3);

    // Test 2: branch from pc=8 to 0x40 with no bubble
    pc_src = 1'b1; pc_target = 32'h8; pc_plus4 = 32'h10;
    cyc();
    pc_target = 32'h40; pc_plus4 = 32'hC;
    #1 chk("br_at8", pc, 32'h8);
    chk("br_valid", {31'b0, instr_valid}, 32'h1);
    cyc();
    imem_ready = 1'b0;
    #1 chk("br_pc", pc, 32'h40);
    chk("br_req", {31'b0, imem_req}, 32'h1);
    chk("br_once", {31'b0, instr_valid}, 32'h0);
    cyc();

    // Test 3: stall then wait at 0x10
    imem_ready = 1'b1; pc_target = 32'h10; pc_plus4 = 32'h44;
    cyc();
    chk("cnt6", fetch_count, 32'h6);
    stall = 1'b1; pc_target = 32'h80; pc_plus4 = 32'h14;
    for (int i = 0; i < 5; i++) begin
      if (i == 3) begin
        stall = 1'b0; imem_ready = 1'b0;
      end
      #1 chk("hold_pc", pc, 32'h10);
      chk("hold_valid", {31'b0, instr_valid}, 32'h0);
      chk("hold_req", {31'b0, imem_req}, 32'h1);
      chk("hold_cnt", fetch_count, 32'h6);
      cyc();
    end
    chk("hold_addr", imem_addr, 32'h10);

    // Test 4: misaligned target traps
    imem_ready = 1'b1; pc_src = 1'b1; pc_target = 32'h22;
    #1 chk("mis_accept", {31'b0, instr_valid}, 32'h1);
    cyc();
    stall = 1'b1;
    #1 chk("trap_pc", pc, 32'h100);
    chk("trap_mis", {31'b0, misalign}, 32'h1);
    chk("trap_req", {31'b0, imem_req}, 32'h0);
    chk("trap_valid", {31'b0, instr_valid}, 32'h0);
    chk("trap_cnt", fetch_count, 32'h7);
    cyc();
    stall = 1'b0; pc_src = 1'b0; pc_plus4 = 32'h104;
    #1 chk("tv_req", {31'b0, imem_req}, 32'h1);
    chk("tv_addr", imem_addr, 32'h100);
    cyc();
    pc_src = 1'b1; pc_target = 32'h40;
    #1 chk("post_pc", pc, 32'h104);
    chk("post_mis", {31'b0, misalign}, 32'h1);
    cyc();
    imem_ready = 1'b0;
    chk("post2_pc", pc, 32'h40);
    chk("post2_mis", {31'b0, misalign}, 32'h1);
    chk("post2_cnt", fetch_count, 32'h9);

    // Test 5: async reset between edges
    #3 reset = 1'b1;
    #1 chk("ar_pc", pc, 32'h0);
    chk("ar_cnt", fetch_count, 32'h0);
    chk("ar_mis", {31'b0, misalign}, 32'h0);
    chk("ar_req", {31'b0, imem_req}, 32'h0);
    cyc();
    reset = 1'b0;
    cyc();

    // Test 6: PC wraps from all-ones word to 0
    imem_ready = 1'b1; pc_src = 1'b1; pc_target = 32'hFFFF_FFFC;
    #1 chk("w_addr", imem_addr, 32'h0);
    cyc();
    pc_src = 1'b0; pc_plus4 = 32'h0;
    #1 chk("w_top", pc, 32'hFFFF_FFFC);
    cyc();
    chk("w_pc", pc, 32'h0);
    chk("w_mis", {31'b0, misalign}, 32'h0);
    chk("w_cnt", fetch_count, 32'h2);

    // Counter wrap on the 8-bit instance: 256 accepts
    reset8 = 1'b0;
    cyc();
    chk("n_req", {31'b0, req8}, 32'h1);
    repeat (255) cyc();
    chk("n_cnt_ff", {24'b0, cnt8}, 32'hFF);
    chk("n_pc_fc", {24'b0, pc8}, 32'hFC);
    chk("n_valid", {31'b0, valid8}, 32'h1);
    cyc();
    chk("n_cnt_wrap", {24'b0, cnt8}, 32'h0);
    chk("n_pc_wrap", {24'b0, addr8}, 32'h0);
    chk("n_mis", {31'b0, mis8}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
